// File: rtl/core_insn_queue.sv
// core_insn_queue: sequential word prefetch queue presenting the head word as a lo/hi halfword pair,
// with branch redirect (odd halfword targets) and halt-driven flush/rewind.
module core_insn_queue #(
  parameter int PREFETCH_ORDER = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic [30:0] target,
  input  logic        halt,
  input  logic        stall,
  output logic        fetch,
  output logic [29:0] addr,
  input  logic        fetched,
  input  logic [31:0] fetch_data,
  output logic        out_valid,
  output logic        lo_valid,
  output logic        hi_valid,
  output logic [15:0] lo_insn,
  output logic [15:0] hi_insn,
  output logic [30:0] lo_insn_pc,
  output logic [30:0] hi_insn_pc,
  output logic        idle
);
  localparam int DEPTH = 1 << PREFETCH_ORDER;
  localparam int PW = PREFETCH_ORDER;

  logic [31:0]   data_q  [DEPTH];
  logic [29:0]   waddr_q [DEPTH];
  logic          fetch_q, fetch_d, outstanding_q, outstanding_d;
  logic          discard_q, discard_d, skip_lo_q, skip_lo_d;
  logic [29:0]   addr_q, addr_d, next_addr_q, next_addr_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic          flush, issue, push, pop;

  assign fetch      = fetch_q;
  assign addr       = addr_q;
  assign idle       = !outstanding_q;
  assign out_valid  = count_q != '0;
  assign hi_valid   = out_valid;
  assign lo_valid   = out_valid && !skip_lo_q;
  assign lo_insn    = out_valid ? data_q[head_q][15:0] : '0;
  assign hi_insn    = out_valid ? data_q[head_q][31:16] : '0;
  assign lo_insn_pc = out_valid ? {waddr_q[head_q], 1'b0} : '0;
  assign hi_insn_pc = out_valid ? {waddr_q[head_q], 1'b1} : '0;

  always_comb begin
    flush         = branch || halt;
    issue         = !flush && !outstanding_q && (count_q < (PW+1)'(DEPTH));
    push          = fetched && outstanding_q && !discard_q && !flush;
    pop           = out_valid && !stall && !flush;
    fetch_d       = issue;
    addr_d        = issue ? next_addr_q : addr_q;
    next_addr_d   = issue ? next_addr_q + 30'd1 : next_addr_q;
    outstanding_d = issue || (outstanding_q && !fetched);
    discard_d     = discard_q && !(fetched && outstanding_q);
    skip_lo_d     = pop ? 1'b0 : skip_lo_q;
    count_d       = count_q + (PW+1)'(push) - (PW+1)'(pop);
    head_d        = head_q + PW'(pop);
    tail_d        = tail_q + PW'(push);
    // rewind to the oldest word the decoders have not yet consumed
    if (halt)
      next_addr_d = count_q != '0 ? waddr_q[head_q] : outstanding_q ? addr_q : next_addr_q;
    if (branch) begin
      next_addr_d = target[30:1];
      skip_lo_d   = target[0];
    end
    if (flush) begin
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      discard_d = outstanding_q && !fetched;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q]  <= fetch_data;
      waddr_q[tail_q] <= addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q       <= 1'b0;
      addr_q        <= '0;
      next_addr_q   <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      skip_lo_q     <= 1'b0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      fetch_q       <= fetch_d;
      addr_q        <= addr_d;
      next_addr_q   <= next_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      skip_lo_q     <= skip_lo_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end
endmodule

// File: tb/tb_core_insn_queue.sv
// tb_core_insn_queue: scoreboard bench for the prefetch queue; a memory model answers
// each fetch two cycles later with word n = 32'hA000_0000 + n.
module tb_core_insn_queue;
  logic        clk = 0, rst_n = 1, branch = 0, halt = 0, stall = 0;
  logic [30:0] target = 0;
  logic        fetched, fetch, out_valid, lo_valid, hi_valid, idle;
  logic [31:0] fetch_data;
  logic [29:0] addr;
  logic [15:0] lo_insn, hi_insn;
  logic [30:0] lo_insn_pc, hi_insn_pc;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [30:0] lpc;
    logic [30:0] hpc;
    logic        lv;
  } pair_t;

  pair_t       sb[$];
  int          n_chk = 0, n_pass = 0, n_pops = 0, n_fetch = 0;
  bit          sb_en = 0;
  int          dly;
  logic [29:0] req_a;

  always #5 clk = ~clk;

  core_insn_queue #(.PREFETCH_ORDER(2)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .target(target), .halt(halt), .stall(stall),
    .fetch(fetch), .addr(addr), .fetched(fetched), .fetch_data(fetch_data),
    .out_valid(out_valid), .lo_valid(lo_valid), .hi_valid(hi_valid),
    .lo_insn(lo_insn), .hi_insn(hi_insn), .lo_insn_pc(lo_insn_pc), .hi_insn_pc(hi_insn_pc),
    .idle(idle)
  );

  // memory model: answers a request seen on a falling edge two falling edges later
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly = 0;
      fetched = 0;
      fetch_data = 0;
    end else begin
      fetched = 0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          fetched = 1;
          fetch_data = 32'hA000_0000 + {2'b0, req_a};
        end
      end
      if (fetch) begin
        dly = 2;
        req_a = addr;
      end
    end
  end

  function automatic pair_t mk(logic [29:0] a, bit skip);
    logic [31:0] d;
    d = 32'hA000_0000 + {2'b0, a};
    mk = '{lo: d[15:0], hi: d[31:16], lpc: {a, 1'b0}, hpc: {a, 1'b1}, lv: !skip};
  endfunction

  // compares the head pair against the scoreboard when it will pop, then advances one cycle
  task automatic tick;
    pair_t e;
    if (sb_en && out_valid && !stall && !branch && !halt) begin
      n_pops++;
      n_chk++;
      if (sb.size() == 0)
        $display("FAIL sb_empty: pair popped lo=%h hi=%h with nothing expected", lo_insn, hi_insn);
      else begin
        e = sb.pop_front();
        if ({lo_insn, hi_insn, lo_insn_pc, hi_insn_pc, lo_valid, hi_valid} !== {e.lo, e.hi, e.lpc, e.hpc, e.lv, 1'b1})
          $display("FAIL pair: got lo=%h hi=%h lpc=%h hpc=%h lv=%b hv=%b, want lo=%h hi=%h lpc=%h hpc=%h lv=%b hv=1",
                   lo_insn, hi_insn, lo_insn_pc, hi_insn_pc, lo_valid, hi_valid, e.lo, e.hi, e.lpc, e.hpc, e.lv);
        else n_pass++;
      end
    end
    @(negedge clk);
    if (fetch) n_fetch++;
  endtask

  task automatic do_reset;
    sb.delete();
    sb_en = 0;
    branch = 0;
    halt = 0;
    stall = 0;
    target = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_fetch = 0;
    n_pops = 0;
    rst_n = 1;
    sb_en = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    @(negedge clk);
    n_chk++;
    if ({fetch, out_valid, lo_valid, hi_valid, idle} !== 5'b00001)
      $display("FAIL reset_flags: got %b want 00001", {fetch, out_valid, lo_valid, hi_valid, idle});
    else n_pass++;
    n_chk++;
    if (addr !== 30'd0) $display("FAIL reset_addr: got %h want 0", addr); else n_pass++;
    n_chk++;
    if ({lo_insn, hi_insn} !== 32'd0) $display("FAIL reset_insn: got %h want 0", {lo_insn, hi_insn}); else n_pass++;
    n_chk++;
    if ({lo_insn_pc, hi_insn_pc} !== 62'd0) $display("FAIL reset_pc: got %h/%h want 0", lo_insn_pc, hi_insn_pc); else n_pass++;
  endtask

  task automatic test_sequential;
    logic [29:0] exp_a;
    int cyc;
    do_reset();
    for (int n = 0; n < 12; n++) sb.push_back(mk(30'(n), 0));
    tick();
    n_chk++;
    if (fetch !== 1'b1 || addr !== 30'd0) $display("FAIL first_issue: fetch=%b addr=%h want 1/0", fetch, addr);
    else n_pass++;
    exp_a = 1;
    cyc = 0;
    while (n_pops < 8 && cyc < 300) begin
      tick();
      cyc++;
      if (fetch) begin
        n_chk++;
        if (addr !== exp_a || idle !== 1'b0)
          $display("FAIL seq_fetch: addr=%h idle=%b want %h/0", addr, idle, exp_a);
        else n_pass++;
        exp_a++;
      end
    end
    if (n_pops < 8) begin
      n_chk++;
      $display("FAIL seq_timeout: pops=%0d want 8", n_pops);
    end
  endtask

  task automatic test_stall;
    int cyc;
    bit first;
    do_reset();
    stall = 1;
    repeat (40) tick();
    n_chk++;
    if (n_fetch !== 4) $display("FAIL stall_fetches: got %0d want 4", n_fetch); else n_pass++;
    n_chk++;
    if ({fetch, idle, out_valid} !== 3'b011) $display("FAIL stall_state: fetch/idle/valid=%b want 011", {fetch, idle, out_valid});
    else n_pass++;
    n_chk++;
    if ({hi_insn, lo_insn} !== 32'hA000_0000) $display("FAIL stall_head: got %h want a0000000", {hi_insn, lo_insn});
    else n_pass++;
    for (int n = 0; n < 8; n++) sb.push_back(mk(30'(n), 0));
    stall = 0;
    first = 1;
    cyc = 0;
    while (n_pops < 6 && cyc < 200) begin
      tick();
      cyc++;
      if (fetch && first) begin
        first = 0;
        n_chk++;
        if (addr !== 30'd4) $display("FAIL stall_resume: addr=%h want 4", addr); else n_pass++;
      end
    end
    if (n_pops < 6 || first) begin
      n_chk++;
      $display("FAIL stall_timeout: pops=%0d resumed=%b", n_pops, !first);
    end
  endtask

  task automatic test_branch_outstanding;
    int cyc;
    bit first;
    do_reset();
    tick();
    branch = 1;
    target = 31'h21;
    tick();
    branch = 0;
    sb.push_back(mk(30'h10, 1));
    sb.push_back(mk(30'h11, 0));
    sb.push_back(mk(30'h12, 0));
    first = 1;
    cyc = 0;
    while (n_pops < 2 && cyc < 100) begin
      tick();
      cyc++;
      if (fetch && first) begin
        first = 0;
        n_chk++;
        if (addr !== 30'h10) $display("FAIL br_out_addr: addr=%h want 10", addr); else n_pass++;
      end
    end
    if (n_pops < 2 || first) begin
      n_chk++;
      $display("FAIL br_out_timeout: pops=%0d", n_pops);
    end
  endtask

  task automatic test_branch_at_fetched;
    int cyc;
    bit first;
    do_reset();
    tick();
    n_chk++;
    if (n_fetch !== 1) $display("FAIL br_fd_issue: fetches=%0d want 1", n_fetch); else n_pass++;
    tick();
    tick();
    branch = 1;
    target = 31'h40;
    tick();
    branch = 0;
    sb.push_back(mk(30'h20, 0));
    sb.push_back(mk(30'h21, 0));
    sb.push_back(mk(30'h22, 0));
    first = 1;
    cyc = 0;
    while (n_pops < 2 && cyc < 100) begin
      tick();
      cyc++;
      if (fetch && first) begin
        first = 0;
        n_chk++;
        if (addr !== 30'h20) $display("FAIL br_fd_addr: addr=%h want 20", addr); else n_pass++;
      end
    end
    if (n_pops < 2 || first) begin
      n_chk++;
      $display("FAIL br_fd_timeout: pops=%0d", n_pops);
    end
  endtask

  task automatic test_halt;
    int cyc;
    bit first, bad;
    do_reset();
    for (int n = 0; n < 5; n++) sb.push_back(mk(30'(n), 0));
    cyc = 0;
    while (n_pops < 5 && cyc < 200) begin
      tick();
      cyc++;
    end
    stall = 1;
    repeat (30) tick();
    n_chk++;
    if (out_valid !== 1'b1 || lo_insn !== 16'h0005) $display("FAIL halt_head: valid=%b lo=%h want 1/0005", out_valid, lo_insn);
    else n_pass++;
    halt = 1;
    bad = 0;
    repeat (3) begin
      tick();
      if (out_valid !== 1'b0 || fetch !== 1'b0) bad = 1;
    end
    n_chk++;
    if (bad) $display("FAIL halt_flush: valid=%b fetch=%b want 0/0", out_valid, fetch); else n_pass++;
    halt = 0;
    stall = 0;
    for (int n = 5; n < 9; n++) sb.push_back(mk(30'(n), 0));
    first = 1;
    cyc = 0;
    while (n_pops < 8 && cyc < 200) begin
      tick();
      cyc++;
      if (fetch && first) begin
        first = 0;
        n_chk++;
        if (addr !== 30'd5) $display("FAIL halt_resume: addr=%h want 5", addr); else n_pass++;
      end
    end
    if (n_pops < 8 || first) begin
      n_chk++;
      $display("FAIL halt_timeout: pops=%0d", n_pops);
    end
  endtask

  task automatic test_wrap_and_async_reset;
    int cyc, k;
    do_reset();
    branch = 1;
    target = 31'h7FFF_FFFE;
    sb.push_back(mk(30'h3FFF_FFFF, 0));
    sb.push_back(mk(30'h0, 0));
    tick();
    branch = 0;
    k = 0;
    cyc = 0;
    while (n_pops < 2 && cyc < 100) begin
      tick();
      cyc++;
      if (fetch && k < 2) begin
        n_chk++;
        if (addr !== (k == 0 ? 30'h3FFF_FFFF : 30'h0))
          $display("FAIL wrap_addr%0d: addr=%h want %h", k, addr, (k == 0 ? 30'h3FFF_FFFF : 30'h0));
        else n_pass++;
        k++;
      end
    end
    if (n_pops < 2) begin
      n_chk++;
      $display("FAIL wrap_timeout: pops=%0d", n_pops);
    end
    sb_en = 0;
    stall = 1;
    cyc = 0;
    tick();
    while (!fetch && cyc < 50) begin
      tick();
      cyc++;
    end
    n_chk++;
    if (!fetch || !out_valid) $display("FAIL midfetch_setup: fetch=%b valid=%b want 1/1", fetch, out_valid);
    else n_pass++;
    rst_n = 0;
    #1;
    n_chk++;
    if ({fetch, out_valid, lo_valid, hi_valid, idle} !== 5'b00001 || addr !== 30'd0 ||
        {lo_insn, hi_insn} !== 32'd0 || {lo_insn_pc, hi_insn_pc} !== 62'd0)
      $display("FAIL async_reset: flags=%b addr=%h insn=%h pcs=%h/%h want 00001/0/0/0",
               {fetch, out_valid, lo_valid, hi_valid, idle}, addr, {lo_insn, hi_insn}, lo_insn_pc, hi_insn_pc);
    else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_outstanding();
    test_branch_at_fetched();
    test_halt();
    test_wrap_and_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
